// File: rtl/layer_output_serializer.sv
// Buffers one layer's neuron results and streams them in index order over a valid/ready handshake.
// Latency: first word one cycle after the last capture. Up to 1 word/cycle; holds the word while out_ready is low.
module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    input  logic                              out_ready,
    input  logic                              err_clr,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic [IDX_WIDTH-1:0]              out_index,
    output logic                              busy,
    output logic                              layer_done,
    output logic                              err_overrun
);

    typedef enum logic {COLLECT, SEND} state_t;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] captured_q, captured_d, capture_en;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   layer_done_d;
    logic                   overrun;
    logic                   last_idx;
    logic [DATA_WIDTH-1:0]  data_buf [NUM_NEURONS];

    always_comb begin
        state_d      = state_q;
        captured_d   = captured_q;
        idx_d        = idx_q;
        layer_done_d = 1'b0;
        capture_en   = '0;
        overrun      = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        out_data     = '0;
        out_index    = '0;
        last_idx     = (idx_q == IDX_WIDTH'(NUM_NEURONS - 1));

        case (state_q)
            COLLECT: begin
                capture_en = neuron_valid & ~captured_q;
                overrun    = |(neuron_valid & captured_q);
                captured_d = captured_q | capture_en;
                if (&captured_d) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = data_buf[idx_q];
                out_index = idx_q;
                // Results arriving mid-stream have nowhere to go; they are not carried into the next frame.
                overrun   = |neuron_valid;
                if (out_ready) begin
                    if (last_idx) begin
                        state_d      = COLLECT;
                        captured_d   = '0;
                        idx_d        = '0;
                        layer_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= COLLECT;
            captured_q  <= '0;
            idx_q       <= '0;
            layer_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            idx_q      <= idx_d;
            layer_done <= layer_done_d;
            if (overrun)
                err_overrun <= 1'b1;
            else if (err_clr)
                err_overrun <= 1'b0;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (capture_en[i])
                data_buf[i] <= neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with 4 neurons of 16 bits.
module tb_layer_output_serializer;

    localparam int NN = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NN*DW-1:0] neuron_out;
    logic [NN-1:0]   neuron_valid;
    logic            out_ready;
    logic            err_clr;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic [IW-1:0]   out_index;
    logic            busy;
    logic            layer_done;
    logic            err_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    layer_output_serializer #(.NUM_NEURONS(NN), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .out_ready    (out_ready),
        .err_clr      (err_clr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_index    (out_index),
        .busy         (busy),
        .layer_done   (layer_done),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [NN-1:0] mask, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
        neuron_out   = {w3, w2, w1, w0};
        neuron_valid = mask;
    endtask

    // Called in the first SEND cycle with out_ready high; ends in the cycle after the last handshake.
    task automatic drain(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w [NN];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        out_ready = 1'b1;
        for (int i = 0; i < NN; i++) begin
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"},  32'(out_data),  32'(w[i]));
            check({tag, "_index"}, 32'(out_index), 32'(i));
            step();
        end
        check({tag, "_done"},  32'(layer_done), 32'd1);
        check({tag, "_idle"},  32'(out_valid),  32'd0);
    endtask

    initial begin
        rst = 1'b0; neuron_out = '0; neuron_valid = '0; out_ready = 1'b1; err_clr = 1'b0;
        step(); step();
        check("rst_valid", 32'(out_valid),   32'd0);
        check("rst_data",  32'(out_data),    32'd0);
        check("rst_index", 32'(out_index),   32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(layer_done),  32'd0);
        check("rst_err",   32'(err_overrun), 32'd0);
        rst = 1'b1;
        step();

        // 1: all four in one cycle
        load(4'hF, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        step();
        neuron_valid = '0;
        check("t1_busy", 32'(busy), 32'd1);
        drain("t1", 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        step();
        check("t1_done_pulse", 32'(layer_done), 32'd0);

        // 2: staggered 2,0,3,1 on cycles 0,3,5,9
        neuron_out = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
        for (int c = 0; c < 10; c++) begin
            case (c)
                0: neuron_valid = 4'b0100;
                3: neuron_valid = 4'b0001;
                5: neuron_valid = 4'b1000;
                9: neuron_valid = 4'b0010;
                default: neuron_valid = 4'b0000;
            endcase
            if (c == 4 || c == 9) check("t2_wait", 32'(out_valid), 32'd0);
            step();
        end
        neuron_valid = '0;
        drain("t2", 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03);

        // 3: stall on word 1 for three cycles
        load(4'hF, 16'h3000, 16'h3001, 16'h3002, 16'h3003);
        step();
        neuron_valid = '0;
        check("t3_w0", 32'(out_data), 32'h3000);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_data",  32'(out_data),  32'h3001);
            check("t3_hold_index", 32'(out_index), 32'd1);
            step();
        end
        out_ready = 1'b1;
        check("t3_resume", 32'(out_data), 32'h3001);
        step();
        check("t3_w2", 32'(out_data), 32'h3002);
        step();
        check("t3_w3", 32'(out_data), 32'h3003);
        step();
        check("t3_done", 32'(layer_done), 32'd1);

        // 4: duplicate result on neuron 0 keeps the first value
        load(4'b0001, 16'hAAAA, 16'h0, 16'h0, 16'h0);
        step();
        load(4'b0001, 16'hBBBB, 16'h0, 16'h0, 16'h0);
        step();
        check("t4_err_set", 32'(err_overrun), 32'd1);
        load(4'b1110, 16'hBBBB, 16'h4001, 16'h4002, 16'h4003);
        step();
        neuron_valid = '0;
        drain("t4", 16'hAAAA, 16'h4001, 16'h4002, 16'h4003);
        check("t4_err_sticky", 32'(err_overrun), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_err_clr", 32'(err_overrun), 32'd0);

        // 5: neuron 2 on the final handshake, with err_clr at the same time
        load(4'hF, 16'h5000, 16'h5001, 16'h5002, 16'h5003);
        step();
        neuron_valid = '0;
        step(); step(); step();
        check("t5_last_idx", 32'(out_index), 32'd3);
        neuron_valid = 4'b0100;
        err_clr = 1'b1;
        step();
        neuron_valid = '0;
        err_clr = 1'b0;
        check("t5_done", 32'(layer_done),  32'd1);
        check("t5_err",  32'(err_overrun), 32'd1);
        load(4'b1011, 16'h6000, 16'h6001, 16'h6002, 16'h6003);
        step();
        neuron_valid = '0;
        check("t5_wait2", 32'(out_valid), 32'd0);
        load(4'b0100, 16'h6000, 16'h6001, 16'h6222, 16'h6003);
        step();
        neuron_valid = '0;
        drain("t5", 16'h6000, 16'h6001, 16'h6222, 16'h6003);

        // 6: reset in the middle of a frame
        load(4'hF, 16'h7000, 16'h7001, 16'h7002, 16'h7003);
        step();
        neuron_valid = '0;
        step(); step();
        check("t6_at_idx2", 32'(out_index), 32'd2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_rst_valid", 32'(out_valid),   32'd0);
        check("t6_rst_data",  32'(out_data),    32'd0);
        check("t6_rst_index", 32'(out_index),   32'd0);
        check("t6_rst_busy",  32'(busy),        32'd0);
        check("t6_rst_err",   32'(err_overrun), 32'd0);
        step();
        check("t6_idle", 32'(out_valid), 32'd0);
        load(4'hF, 16'h8000, 16'h8001, 16'h8002, 16'h8003);
        step();
        neuron_valid = '0;
        drain("t6", 16'h8000, 16'h8001, 16'h8002, 16'h8003);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
